md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  RV32M execute unit. Consumes the decoder's 5-bit ALU op codes 5'b10000..5'b10111 (MUL..REMU) with ID/EX operands.
//  MUL* ops complete in 1 cycle; DIV*/REM* use an iterative 32-step restoring divider.
//  Sits in EX beside the main ALU. Hazard unit stalls IF/ID/EX on o_busy; the WB mux takes o_result on o_valid.
// PARAMETERS
//  XLEN      32   operand/result width (only 32 is supported)
//  CNT_W     5    divider iteration counter width, = log2(XLEN)
// PORTS
//  i_clk       in   1     clock
//  i_reset     in   1     synchronous reset, active-high
//  i_start     in   1     EX holds a valid M-ext instr (i_alu_op[4]==1); qualified by o_ready
//  i_alu_op    in   5     decoded op; [2:0] selects MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//  i_op_a      in   XLEN  rs1 value (dividend / multiplicand)
//  i_op_b      in   XLEN  rs2 value (divisor / multiplier)
//  i_rd_addr   in   5     destination register tag, carried to o_rd_addr
//  i_flush     in   1     abort the in-flight op (branch mispredict / jump redirect)
//  o_ready     out  1     state==IDLE; i_start is accepted only when high
//  o_busy      out  1     state==DIV; hazard unit holds the pipeline
//  o_valid     out  1     1-cycle pulse: o_result/o_rd_addr valid
//  o_result    out  XLEN  result
//  o_rd_addr   out  5     tag of the completed op
// BEHAVIOUR
//  Reset: state=IDLE, o_valid=0, o_result=0, o_rd_addr=0, counter=0. o_ready=1 and o_busy=0 follow from IDLE.
//  States: IDLE, DIV, DONE. Start accept = i_start & o_ready & !i_flush & i_alu_op[4], in cycle T.
//  IDLE, accepted MUL* or special-case DIV*/REM*:
//   - result computed at T and registered; state->DONE; o_valid=1 at T+1.
//  IDLE, accepted normal DIV*/REM*:
//   - latch |a|, |b| (signed ops) or raw operands (unsigned ops), quotient and result signs; counter=31; state->DIV.
//   - one quotient bit per cycle, MSB first, counter decrements.
//   - at counter==0: state->DONE, sign fix-up applied; o_valid=1 at T+33.
//  DONE: o_valid=1 for exactly 1 cycle -> IDLE. i_start is ignored in DONE (o_ready=0).
//  MUL arithmetic: 64-bit product of 33-bit sign/zero-extended operands.
//   - MUL = prod[31:0]; MULH = s*s; MULHSU = s(a)*u(b); MULHU = u*u. MULH* return prod[63:32].
//  DIV arithmetic: quotient truncates toward zero; REM takes the sign of the dividend.
//  Special cases, 1-cycle path:
//   - b==0: DIV/DIVU=32'hFFFF_FFFF; REM/REMU=a.
//   - signed overflow (a=32'h8000_0000, b=-1): DIV=32'h8000_0000; REM=0.
//  i_flush: any state -> IDLE next cycle; no o_valid pulse; datapath regs need not clear.
//   - A flush in the same cycle as a DONE pulse suppresses that pulse.
//  i_reset mid-operation: identical to reset; the op is discarded.
//  i_start with i_alu_op[4]==0: ignored. A start while not ready: ignored, because the pipeline is stalled and re-presents it.
//  o_result and o_rd_addr hold their last value outside o_valid.
// STRUCTURE
//  md_pkg: md_state_e {IDLE,DIV,DONE}; localparams for the 8 funct3 op codes; XLEN.
//  Sub-module md_div_core: unsigned restoring divider step (remainder/quotient shift-subtract, counter, done flag).
//   - md_unit owns the FSM, sign handling, special cases, multiplier and output registers.
// TESTING
//  MUL a=7 b=-3 -> o_valid at T+1, o_result=32'hFFFF_FFEB (-21).
//  MULH a=32'h8000_0000 b=32'h8000_0000 -> 32'h4000_0000. MULHU a=b=32'hFFFF_FFFF -> 32'hFFFF_FFFE.
//  DIV a=-20 b=3 -> o_valid exactly at T+33, o_result=-6. REM same operands -> -2.
//   - o_busy high for cycles T+1..T+32.
//  DIVU a=100 b=0 -> 32'hFFFF_FFFF at T+1. REM a=32'h8000_0000 b=-1 -> 0 at T+1.
//  DIVU started, i_flush at T+10 -> IDLE at T+11, no o_valid ever; a new MUL at T+11 completes normally.
//  i_reset asserted at T+5 of a DIV -> o_valid=0, o_ready=1 next cycle; i_start while o_busy=1 is ignored.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared types, widths and funct3 op codes for the RV32M execute unit
package md_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;
    typedef enum logic [1:0] {IDLE, DIV, DONE} md_state_e;
endpackage

// File: rtl/md_div_core.sv
// md_div_core: unsigned restoring divider, one quotient bit per step, MSB first
module md_div_core
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] q_next,
    output logic [XLEN-1:0] r_next,
    output logic            last
);
    logic [XLEN-1:0]  rem, quo, dvs;
    logic [CNT_W-1:0] cnt;
    logic [XLEN:0]    trial;
    // a borrow out of the 33-bit trial subtraction means the divisor did not fit
    assign trial  = {rem, quo[XLEN-1]} - {1'b0, dvs};
    assign q_next = {quo[XLEN-2:0], ~trial[XLEN]};
    assign r_next = trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : trial[XLEN-1:0];
    assign last   = cnt == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
            cnt <= CNT_W'(XLEN - 1);
        end else if (step) begin
            rem <= r_next;
            quo <= q_next;
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: RV32M execute unit with single-cycle multiply and 32-step iterative divide
module md_unit
    import md_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [4:0]      i_alu_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_addr
);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    md_state_e state, state_n;
    logic [2:0] op;
    logic accept, is_div, sgn, b_zero, ovf, div_path, neg_a, neg_b, last, last_step;
    logic q_neg, r_neg, rem_sel, unused;
    logic [4:0] tag;
    logic signed [XLEN:0] a_ext, b_ext;
    logic signed [2*XLEN-1:0] prod;
    logic [XLEN-1:0] mul_res, spec_res, q_next, r_next, div_res;
    assign unused   = i_alu_op[3];
    assign op       = i_alu_op[2:0];
    assign o_ready  = state == IDLE;
    assign o_busy   = state == DIV;
    assign o_valid  = state == DONE && !i_flush;
    assign accept   = i_start & o_ready & ~i_flush & i_alu_op[4];
    assign is_div   = op[2];
    assign sgn      = ~op[0];
    assign b_zero   = i_op_b == '0;
    assign ovf      = sgn & (i_op_a == MIN_INT) & (&i_op_b);
    assign div_path = accept & is_div & ~(b_zero | ovf);
    assign a_ext    = {(op == OP_MULH || op == OP_MULHSU) & i_op_a[XLEN-1], i_op_a};
    assign b_ext    = {(op == OP_MULH) & i_op_b[XLEN-1], i_op_b};
    assign prod     = (2*XLEN)'(a_ext) * (2*XLEN)'(b_ext);
    assign mul_res  = op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign spec_res = b_zero ? (op[1] ? i_op_a : '1) : (op[1] ? '0 : MIN_INT);
    assign neg_a    = sgn & i_op_a[XLEN-1];
    assign neg_b    = sgn & i_op_b[XLEN-1];
    assign last_step = o_busy & last & ~i_flush;
    assign div_res  = rem_sel ? (r_neg ? -r_next : r_next) : (q_neg ? -q_next : q_next);
    md_div_core u_core (
        .clk      (i_clk),
        .rst      (i_reset),
        .load     (div_path),
        .step     (o_busy),
        .dividend (neg_a ? -i_op_a : i_op_a),
        .divisor  (neg_b ? -i_op_b : i_op_b),
        .q_next   (q_next),
        .r_next   (r_next),
        .last     (last)
    );
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (i_flush) state_n = IDLE;
        else if (state == IDLE) state_n = accept ? (div_path ? DIV : DONE) : IDLE;
        else if (state == DIV) state_n = last ? DONE : DIV;
        else state_n = IDLE;
    end
    // outputs only change when a result is produced, so they hold between pulses
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_result  <= '0;
            o_rd_addr <= '0;
            tag       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            rem_sel   <= 1'b0;
        end else begin
            if (accept && !div_path) begin
                o_result  <= is_div ? spec_res : mul_res;
                o_rd_addr <= i_rd_addr;
            end
            if (div_path) begin
                tag     <= i_rd_addr;
                q_neg   <= neg_a ^ neg_b;
                r_neg   <= neg_a;
                rem_sel <= op[1];
            end
            if (last_step) begin
                o_result  <= div_res;
                o_rd_addr <= tag;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit against a 64-bit arithmetic reference model
module tb_md_unit;
    logic        i_clk = 1'b0, i_reset, i_start, i_flush;
    logic [4:0]  i_alu_op, i_rd_addr, o_rd_addr;
    logic [31:0] i_op_a, i_op_b, o_result;
    logic        o_ready, o_busy, o_valid;
    typedef struct {logic [31:0] res; logic [4:0] rd; int at;} exp_t;
    exp_t sb[$];
    exp_t e_mon;
    int cyc = 0, total = 0, bad = 0, busy_cnt = 0, b0 = 0;

    md_unit dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_alu_op(i_alu_op),
        .i_op_a(i_op_a), .i_op_b(i_op_b), .i_rd_addr(i_rd_addr), .i_flush(i_flush),
        .o_ready(o_ready), .o_busy(o_busy), .o_valid(o_valid),
        .o_result(o_result), .o_rd_addr(o_rd_addr)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = (ua * ub) >> 32;
            3'd4: p = (b == 0) ? -1 : sa / sb;
            3'd5: p = (b == 0) ? -1 : ua / ub;
            3'd6: p = (b == 0) ? ua : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2] || b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push);
        int n = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        if (!o_ready) check("ready_timeout", {31'b0, o_ready}, 32'd1);
        i_start = 1'b1; i_alu_op = {2'b10, op}; i_op_a = a; i_op_b = b; i_rd_addr = rd;
        if (push) sb.push_back('{model(op, a, b), rd, cyc + lat(op, a, b)});
        tick();
        i_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_flush = 1'b0;
        i_alu_op = '0; i_op_a = '0; i_op_b = '0; i_rd_addr = '0;
        fork
            forever begin
                @(negedge i_clk);
                if (o_busy) busy_cnt++;
                if (o_valid) begin
                    if (sb.size() == 0) check("unexpected_valid", o_result, 32'hxxxx_xxxx);
                    else begin
                        e_mon = sb.pop_front();
                        check("result", o_result, e_mon.res);
                        check("rd_addr", {27'b0, o_rd_addr}, {27'b0, e_mon.rd});
                        check("latency", cyc, e_mon.at);
                    end
                end
            end
        join_none
        repeat (3) tick();
        i_reset = 1'b0;
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_rd", {27'b0, o_rd_addr}, 32'd0);

        issue(3'd0, 32'd7, -32'sd3, 5'd1, 1'b1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
        drain();
        b0 = busy_cnt;
        issue(3'd4, -32'sd20, 32'd3, 5'd4, 1'b1);
        drain();
        check("busy_cycles", busy_cnt - b0, 32'd32);
        issue(3'd6, -32'sd20, 32'd3, 5'd5, 1'b1);
        issue(3'd5, 32'd100, 32'd0, 5'd6, 1'b1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);
        drain();

        // flushed DIVU must never pulse; MUL right after the flush completes normally
        issue(3'd5, 32'd1000, 32'd7, 5'd9, 1'b0);
        repeat (9) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush_ready", {31'b0, o_ready}, 32'd1);
        issue(3'd0, 32'd5, 32'd6, 5'd10, 1'b1);
        drain();

        issue(3'd0, 32'd9, 32'd9, 5'd11, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;

        issue(3'd4, 32'd12345, 32'd17, 5'd12, 1'b0);
        repeat (4) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("midrst_ready", {31'b0, o_ready}, 32'd1);
        check("midrst_valid", {31'b0, o_valid}, 32'd0);

        issue(3'd7, 32'd1000, 32'd7, 5'd13, 1'b1);
        i_start = 1'b1; i_alu_op = 5'b10000; i_op_a = 32'd3; i_op_b = 32'd4; i_rd_addr = 5'd14;
        repeat (3) tick();
        i_start = 1'b0;
        drain();

        i_start = 1'b1; i_alu_op = 5'b00000;
        tick();
        i_start = 1'b0;
        check("non_m_ready", {31'b0, o_ready}, 32'd1);

        for (int i = 0; i < 80; i++) begin
            logic [2:0] op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($signed(16'($urandom))); b = 32'($signed(8'($urandom))); end
                default: ;
            endcase
            issue(op, a, b, 5'($urandom), 1'b1);
        end
        drain();
        repeat (40) tick();
        check("final_queue", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
